bram_arb_port_mux: RTL and testbench

- Downstream consumer of the round-robin scheduler grant inside the BRAM arbiter.
- Muxes N requester command channels onto a single registered BRAM port.
- Tracks which requester owns each in-flight read and steers returning read data back to it.
- Sits between the requester-side command interfaces and the physical BRAM primitive port.

---
 rtl/bram_arb_pkg.sv | 23 ++
 rtl/bram_rd_tag_pipe.sv | 32 +++
 rtl/bram_arb_port_mux.sv | 122 ++++++++++++
 tb/tb_bram_arb_port_mux.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and default sizing for the BRAM arbiter (scheduler, port mux, top).
// Struct field widths follow the BRAM_* defaults below; module parameters must agree with them.
package bram_arb_pkg;

    localparam int BRAM_N      = 4;
    localparam int BRAM_ADDR_W = 10;
    localparam int BRAM_DATA_W = 32;
    localparam int IDX_W       = $clog2(BRAM_N);
    localparam int CNT_W       = 16;

    typedef struct packed {
        logic                   en;
        logic                   we;
        logic [BRAM_ADDR_W-1:0] addr;
        logic [BRAM_DATA_W-1:0] wdata;
    } bram_cmd_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags; the last stage drives the one-hot response valid.
module bram_rd_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int N      = BRAM_N,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  rd_tag_t      tag_i,
    output logic [N-1:0] rsp_vld_o
);

    rd_tag_t stage_q [RD_LAT];

    // NOTE: every stage is reset so a reset drops in-flight reads; this is a register chain, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    // NOTE: default assigned first so no latch is inferred for the unset bits.
    always_comb begin
        rsp_vld_o = '0;
        if (stage_q[RD_LAT-1].vld) rsp_vld_o[stage_q[RD_LAT-1].idx] = 1'b1;
    end

endmodule

// File: rtl/bram_arb_port_mux.sv
// Muxes the granted requester onto a registered BRAM port and steers read data back by tag.
// Optional per-requester grant counters when BRAM_ARB_MUX_STATS_EN is defined.
module bram_arb_port_mux
    import bram_arb_pkg::*;
#(
    parameter int N      = BRAM_N,
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req_vld,
    input  logic [N-1:0]        req_we,
    input  logic [N*ADDR_W-1:0] req_addr,
    input  logic [N*DATA_W-1:0] req_wdata,
    output logic [N-1:0]        req_rdy,
    output logic [N-1:0]        arb_req,
    input  logic [IDX_W-1:0]    grant_idx,
    input  logic                grant_vld,
    output logic                bram_en,
    output logic                bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_wdata,
    input  logic [DATA_W-1:0]   bram_rdata,
    output logic [N-1:0]        rsp_vld,
    output logic [DATA_W-1:0]   rsp_rdata
`ifdef BRAM_ARB_MUX_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [N*CNT_W-1:0]  grant_cnt
`endif
);

    bram_cmd_t        cmd_q, cmd_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             accept;

    assign arb_req = req_vld;
    assign accept  = grant_vld && req_vld[grant_idx];

    always_comb begin
        req_rdy = '0;
        if (accept) req_rdy[grant_idx] = 1'b1;
    end

    // Idle cycles drop en/we but keep addr/wdata, so the port only toggles on real commands.
    always_comb begin
        cmd_d    = cmd_q;
        cmd_d.en = 1'b0;
        cmd_d.we = 1'b0;
        owner_d  = owner_q;
        if (accept) begin
            cmd_d.en    = 1'b1;
            cmd_d.we    = req_we[grant_idx];
            cmd_d.addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
            cmd_d.wdata = req_wdata[grant_idx*DATA_W +: DATA_W];
            owner_d     = grant_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= '0;
            owner_q <= '0;
        end else begin
            cmd_q   <= cmd_d;
            owner_q <= owner_d;
        end
    end

    assign bram_en    = cmd_q.en;
    assign bram_we    = cmd_q.we;
    assign bram_addr  = cmd_q.addr;
    assign bram_wdata = cmd_q.wdata;

    // The tag enters the pipe as the registered command reaches the BRAM.
    rd_tag_t tag_in;
    assign tag_in = '{vld: cmd_q.en & ~cmd_q.we, idx: owner_q};

    bram_rd_tag_pipe #(.N(N), .RD_LAT(RD_LAT)) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_i     (tag_in),
        .rsp_vld_o (rsp_vld)
    );

    assign rsp_rdata = bram_rdata;

`ifdef BRAM_ARB_MUX_STATS_EN
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stats_clr)                        cnt_d[i] = '0;
            else if (req_rdy[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_cnt_out
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

`ifndef SYNTHESIS
    a_grant_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        grant_vld |-> req_vld[grant_idx])
        else $error("grant issued to idle requester %0d", grant_idx);
`endif

endmodule

// File: tb/tb_bram_arb_port_mux.sv
// Self-checking bench for bram_arb_port_mux: directed scenarios plus randomized traffic
// checked against a cycle-indexed scoreboard and a reference memory.
module tb_bram_arb_port_mux;
    import bram_arb_pkg::*;

    localparam int N      = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic                clk;
    logic                rst_n;
    logic [N-1:0]        req_vld;
    logic [N-1:0]        req_we;
    logic [N*ADDR_W-1:0] req_addr;
    logic [N*DATA_W-1:0] req_wdata;
    logic [N-1:0]        req_rdy;
    logic [N-1:0]        arb_req;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_vld;
    logic                bram_en;
    logic                bram_we;
    logic [ADDR_W-1:0]   bram_addr;
    logic [DATA_W-1:0]   bram_wdata;
    logic [DATA_W-1:0]   bram_rdata;
    logic [N-1:0]        rsp_vld;
    logic [DATA_W-1:0]   rsp_rdata;
`ifdef BRAM_ARB_MUX_STATS_EN
    logic                stats_clr;
    logic [N*CNT_W-1:0]  grant_cnt;
    int                  exp_cnt [N];
`endif

    logic [ADDR_W-1:0] r_addr  [N];
    logic [DATA_W-1:0] r_wdata [N];
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr[g*ADDR_W +: ADDR_W]  = r_addr[g];
        assign req_wdata[g*DATA_W +: DATA_W] = r_wdata[g];
    end

    bram_arb_port_mux #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_vld    (req_vld),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rdy    (req_rdy),
        .arb_req    (arb_req),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .rsp_vld    (rsp_vld),
        .rsp_rdata  (rsp_rdata)
`ifdef BRAM_ARB_MUX_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM: read-first, RD_LAT cycles from registered en/addr to data.
    logic [DATA_W-1:0] mem  [1 << ADDR_W];
    logic [DATA_W-1:0] rd_p [RD_LAT];
    logic              mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= DATA_W'(i) * 32'h9E37_79B1;
            mem_init_done <= 1'b1;
        end else if (bram_en && bram_we) begin
            mem[bram_addr] <= bram_wdata;
        end
        rd_p[0] <= (bram_en && !bram_we) ? mem[bram_addr] : $urandom;
        for (int k = 1; k < RD_LAT; k++) rd_p[k] <= rd_p[k-1];
    end
    assign bram_rdata = rd_p[RD_LAT-1];

    // Reference model state.
    int                checks = 0;
    int                errors = 0;
    int                cyc    = 0;
    logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
    int                exp_rsp_idx  [int];
    logic [DATA_W-1:0] exp_rsp_data [int];
    logic              exp_en, exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    logic              last_acc;
    int                last_idx;

    // One clock cycle: inputs already applied at the falling edge.
    task automatic tick();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rsp;
        int           g;
        exp_rdy = '0;
        #1;
        last_acc = 1'b0;
        if (grant_vld && req_vld[grant_idx]) exp_rdy[grant_idx] = 1'b1;
        checks++;
        if (arb_req !== req_vld) begin
            errors++; $display("FAIL arb_req cyc %0d: got %b expected %b", cyc, arb_req, req_vld);
        end
        checks++;
        if (req_rdy !== exp_rdy) begin
            errors++; $display("FAIL req_rdy cyc %0d: got %b expected %b", cyc, req_rdy, exp_rdy);
        end
        exp_rsp = '0;
        if (exp_rsp_idx.exists(cyc)) exp_rsp[exp_rsp_idx[cyc]] = 1'b1;
        checks++;
        if (rsp_vld !== exp_rsp) begin
            errors++; $display("FAIL rsp_vld cyc %0d: got %b expected %b", cyc, rsp_vld, exp_rsp);
        end else if (exp_rsp != '0) begin
            checks++;
            if (rsp_rdata !== exp_rsp_data[cyc]) begin
                errors++;
                $display("FAIL rsp_rdata cyc %0d: got %h expected %h", cyc, rsp_rdata, exp_rsp_data[cyc]);
            end
        end
        if (exp_rdy != '0) begin
            g         = int'(grant_idx);
            last_acc  = 1'b1;
            last_idx  = g;
            exp_en    = 1'b1;
            exp_we    = req_we[g];
            exp_addr  = r_addr[g];
            exp_wdata = r_wdata[g];
            if (req_we[g]) begin
                ref_mem[r_addr[g]] = r_wdata[g];
            end else begin
                exp_rsp_idx[cyc + 1 + RD_LAT]  = g;
                exp_rsp_data[cyc + 1 + RD_LAT] = ref_mem[r_addr[g]];
            end
        end else begin
            exp_en = 1'b0;
            exp_we = 1'b0;
        end
`ifdef BRAM_ARB_MUX_STATS_EN
        for (int i = 0; i < N; i++) begin
            if (stats_clr)                           exp_cnt[i] = 0;
            else if (exp_rdy[i] && exp_cnt[i] < 65535) exp_cnt[i] = exp_cnt[i] + 1;
        end
`endif
        @(posedge clk);
        cyc++;
        @(negedge clk);
        checks++;
        if ({bram_en, bram_we} !== {exp_en, exp_we}) begin
            errors++;
            $display("FAIL bram_en/we cyc %0d: got %b%b expected %b%b", cyc, bram_en, bram_we, exp_en, exp_we);
        end
        checks++;
        if (bram_addr !== exp_addr || bram_wdata !== exp_wdata) begin
            errors++;
            $display("FAIL bram_addr/wdata cyc %0d: got %h/%h expected %h/%h",
                     cyc, bram_addr, bram_wdata, exp_addr, exp_wdata);
        end
    endtask

    task automatic idle(input int n);
        req_vld   = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present one command from requester r and grant it in the same cycle.
    task automatic issue(input int r, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        req_vld    = '0;
        req_vld[r] = 1'b1;
        req_we[r]  = we;
        r_addr[r]  = a;
        r_wdata[r] = d;
        grant_idx  = IDX_W'(r);
        grant_vld  = 1'b1;
        tick();
        req_vld   = '0;
        grant_vld = 1'b0;
    endtask

    task automatic clear_model();
        exp_rsp_idx.delete();
        exp_rsp_data.delete();
        exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
`ifdef BRAM_ARB_MUX_STATS_EN
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
`endif
    endtask

    task automatic test_reset();
        checks++;
        if ({bram_en, bram_we, bram_addr, bram_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_cmd: got %b %b %h %h expected all zero", bram_en, bram_we, bram_addr, bram_wdata);
        end
        checks++;
        if (rsp_vld !== '0 || req_rdy !== '0) begin
            errors++; $display("FAIL reset_rsp_rdy: got %b %b expected 0 0", rsp_vld, req_rdy);
        end
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_single_read();
        issue(2, 1'b0, 10'h055, '0);
        idle(RD_LAT + 2);
    endtask

    task automatic test_write();
        issue(1, 1'b1, 10'h010, 32'hDEAD_BEEF);
        idle(RD_LAT + 2);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < N; r++) issue(r, 1'b0, ADDR_W'(10'h100 + r), '0);
        idle(RD_LAT + 2);
    endtask

    task automatic test_mixed();
        issue(0, 1'b0, 10'h020, '0);
        issue(1, 1'b1, 10'h021, 32'h1234_5678);
        issue(2, 1'b0, 10'h021, '0);
        idle(RD_LAT + 2);
    endtask

    task automatic test_random(input int n);
        int valids [$];
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_vld[i] && $urandom_range(0, 2) != 0) begin
                    req_vld[i] = 1'b1;
                    req_we[i]  = 1'($urandom_range(0, 1));
                    r_addr[i]  = ADDR_W'($urandom_range(0, 15));
                    r_wdata[i] = $urandom;
                end
            end
            valids.delete();
            for (int i = 0; i < N; i++) if (req_vld[i]) valids.push_back(i);
            grant_idx = IDX_W'($urandom_range(0, N - 1));
            grant_vld = 1'b0;
            if (valids.size() > 0 && $urandom_range(0, 3) != 0) begin
                grant_idx = IDX_W'(valids[$urandom_range(0, valids.size() - 1)]);
                grant_vld = 1'b1;
            end
            tick();
            if (last_acc) req_vld[last_idx] = 1'b0;
        end
        idle(RD_LAT + 2);
    endtask

    task automatic test_reset_midflight();
        issue(3, 1'b0, 10'h0AA, '0);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bram_en !== 1'b0 || rsp_vld !== '0) begin
            errors++; $display("FAIL reset_midflight: got en %b rsp %b expected 0 0", bram_en, rsp_vld);
        end
        clear_model();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        idle(RD_LAT + 3);
    endtask

`ifdef BRAM_ARB_MUX_STATS_EN
    task automatic test_stats();
        req_vld    = '0;
        req_vld[3] = 1'b1;
        req_we[3]  = 1'b1;
        r_addr[3]  = 10'h3FF;
        r_wdata[3] = 32'h0;
        grant_idx  = 2'd3;
        grant_vld  = 1'b1;
        for (int i = 0; i < 70000; i++) tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (grant_cnt[i*CNT_W +: CNT_W] !== CNT_W'(exp_cnt[i])) begin
                errors++;
                $display("FAIL grant_cnt_sat[%0d]: got %h expected %h", i, grant_cnt[i*CNT_W +: CNT_W], exp_cnt[i]);
            end
        end
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        idle(1);
        checks++;
        if (grant_cnt[3*CNT_W +: CNT_W] !== 16'h0000) begin
            errors++; $display("FAIL grant_cnt_clr: got %h expected 0000", grant_cnt[3*CNT_W +: CNT_W]);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req_vld   = '0;
        req_we    = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            r_addr[i]  = '0;
            r_wdata[i] = '0;
        end
        for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = DATA_W'(i) * 32'h9E37_79B1;
        last_acc = 1'b0;
        last_idx = 0;
`ifdef BRAM_ARB_MUX_STATS_EN
        stats_clr = 1'b0;
`endif
        clear_model();
        repeat (3) @(negedge clk);
        test_reset();
        test_single_read();
        test_write();
        test_back_to_back();
        test_mixed();
        test_random(400);
        test_reset_midflight();
`ifdef BRAM_ARB_MUX_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
